// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared bridge state encoding, transfer-size codes and AXI constants
package cpu_bus_pkg;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;
endpackage

// File: rtl/bridge_wstrb_gen.sv
// bridge_wstrb_gen: byte-lane strobe from transfer size and low address bits
//   size  in  2  SIZE_BYTE / SIZE_HALF / SIZE_WORD
//   addr  in  2  address bits [1:0]
//   wstrb out 4  active byte lanes
module bridge_wstrb_gen
  import cpu_bus_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr,
  output logic [3:0] wstrb
);
  always_comb
    wstrb = size == SIZE_BYTE ? 4'b0001 << addr :
            size == SIZE_HALF ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
endmodule

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: two sram-like CPU ports (inst, data) onto one AXI master, single outstanding
//   clk, resetn                      clock, async active-low reset
//   inst_* / data_*                  sram-like request/response ports; data has priority
//   ar*/r*/aw*/w*/b*                 AXI master channels (single beat, INCR)
//   bus_err                          one-cycle pulse when the response watchdog expires
// Optional: define BRIDGE_TIMEOUT_EN to enable the response watchdog (TIMEOUT_CYC cycles).
module cpu_axi_bridge
  import cpu_bus_pkg::*;
#(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        bus_err
);
  state_t state, state_nx;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0] size_q;
  logic wr_q, src_q, aw_done, w_done, acc, aw_hs, w_hs, to_hit;
  logic unused;
  assign data_addr_ok = state == IDLE & data_req;
  assign inst_addr_ok = state == IDLE & inst_req & ~data_req;
  assign acc = data_addr_ok | inst_addr_ok;
  assign arvalid = state == RD_ADDR;
  assign rready = state == RD_DATA;
  assign awvalid = state == WR_REQ & ~aw_done;
  assign wvalid = state == WR_REQ & ~w_done;
  assign bready = state == WR_RESP;
  assign aw_hs = awvalid & awready;
  assign w_hs = wvalid & wready;
  assign arid = src_q ? ID_DATA : ID_INST;
  assign awid = ID_DATA;
  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign arlen = 8'd0;
  assign awlen = 8'd0;
  assign arsize = {1'b0, size_q};
  assign awsize = {1'b0, size_q};
  assign arburst = AXI_BURST_INCR;
  assign awburst = AXI_BURST_INCR;
  assign wdata = wdata_q;
  assign wlast = 1'b1;
  assign inst_data_ok = state == RESP & ~src_q;
  assign data_data_ok = state == RESP & src_q;
  assign inst_rdata = rdata_q;
  assign data_rdata = rdata_q;
  bridge_wstrb_gen u_wstrb (.size(size_q), .addr(addr_q[1:0]), .wstrb(wstrb));
`ifdef BRIDGE_TIMEOUT_EN
  logic [7:0] cnt;
  logic to_q;
  assign to_hit = (rready | bready) & cnt == 8'(TIMEOUT_CYC - 1);
  assign bus_err = state == RESP & to_q;
  assign unused = ^{rid, rresp, rlast, bid, bresp};
  // counter is zero on entry to a wait state because it only runs while waiting
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt <= 8'd0;
      to_q <= 1'b0;
    end else begin
      cnt <= rready | bready ? cnt + 8'd1 : 8'd0;
      to_q <= acc ? 1'b0 : to_q | to_hit;
    end
`else
  assign to_hit = 1'b0;
  assign bus_err = 1'b0;
  assign unused = ^{rid, rresp, rlast, bid, bresp, TIMEOUT_CYC[0]};
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc) state_nx = (data_req ? data_wr : inst_wr) ? WR_REQ : RD_ADDR;
      RD_ADDR: if (arready) state_nx = RD_DATA;
      RD_DATA: if (rvalid | to_hit) state_nx = RESP;
      WR_REQ:  if ((aw_done | aw_hs) & (w_done | w_hs)) state_nx = WR_RESP;
      WR_RESP: if (bvalid | to_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      size_q <= 2'd0;
      wr_q <= 1'b0;
      src_q <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      if (acc) begin
        src_q <= data_req;
        wr_q <= data_req ? data_wr : inst_wr;
        addr_q <= data_req ? data_addr : inst_addr;
        size_q <= data_req ? data_size : inst_size;
        wdata_q <= data_req ? data_wdata : inst_wdata;
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if (rready & rvalid) rdata_q <= rdata;
      else if (rready & to_hit & ~wr_q) rdata_q <= DEADBEEF;
    end
endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: directed self-checking bench for cpu_axi_bridge
module tb_cpu_axi_bridge;
  logic clk = 1'b0, resetn = 1'b0;
  logic inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
  logic [1:0] inst_size = 0, data_size = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0] arid, awid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst;
  logic arvalid, rready, awvalid, wvalid, wlast, bready, bus_err;
  logic [3:0] wstrb;
  logic arready = 0, rvalid = 0, rlast = 1, awready = 0, wready = 0, bvalid = 0;
  logic [31:0] rdata = 0;
  logic [3:0] rid = 0, bid = 0;
  logic [1:0] rresp = 0, bresp = 0;
  int n_chk = 0, n_fail = 0;
  int inst_ok_n = 0, data_ok_n = 0, aw_n = 0, w_n = 0, err_n = 0;
  always #5 clk = ~clk;
  cpu_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready), .bus_err(bus_err)
  );
  always @(posedge clk) begin
    if (inst_data_ok) inst_ok_n <= inst_ok_n + 1;
    if (data_data_ok) data_ok_n <= data_ok_n + 1;
    if (awvalid && awready) aw_n <= aw_n + 1;
    if (wvalid && wready) w_n <= w_n + 1;
    if (bus_err) err_n <= err_n + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic req(input logic src, input logic wr, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd);
    if (src) begin
      data_req = 1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
    end else begin
      inst_req = 1; inst_wr = 0; inst_size = sz; inst_addr = a; inst_wdata = wd;
    end
    #1 chk(src ? "data_addr_ok" : "inst_addr_ok", src ? data_addr_ok : inst_addr_ok, 1);
    @(posedge clk); @(negedge clk);
    if (src) data_req = 0; else inst_req = 0;
  endtask
  task automatic rd_txn(input logic src, input logic [31:0] a, input logic [31:0] d, input int lat);
    chk("arvalid", arvalid, 1);
    chk("arid", arid, src ? 32'd1 : 32'd0);
    chk("araddr", araddr, a);
    arready = 1;
    @(posedge clk); @(negedge clk);
    arready = 0;
    chk("ar_drop", arvalid, 0);
    chk("rready", rready, 1);
    repeat (lat) @(negedge clk);
    rvalid = 1; rdata = d;
    @(posedge clk); @(negedge clk);
    rvalid = 0;
    chk("rd_data_ok", src ? data_data_ok : inst_data_ok, 1);
    chk("rd_other_ok", src ? inst_data_ok : data_data_ok, 0);
    chk("rd_rdata", src ? data_rdata : inst_rdata, d);
    @(negedge clk);
    chk("rd_ok_pulse", src ? data_data_ok : inst_data_ok, 0);
  endtask
  task automatic wr_txn(input int ad, input int wd);
    int a0 = aw_n, w0 = w_n, d0 = data_ok_n, c = 0;
    while ((aw_n == a0 || w_n == w0) && c < 20) begin
      awready = c >= ad; wready = c >= wd;
      @(posedge clk); @(negedge clk);
      c++;
    end
    chk("wr_both_done", (aw_n != a0) && (w_n != w0), 1);
    chk("wr_awvalid_drop", awvalid, 0);
    chk("wr_wvalid_drop", wvalid, 0);
    chk("wr_bready", bready, 1);
    @(posedge clk); @(negedge clk);
    awready = 0; wready = 0;
    chk("aw_once", aw_n - a0, 1);
    chk("w_once", w_n - w0, 1);
    bvalid = 1;
    @(posedge clk); @(negedge clk);
    bvalid = 0;
    chk("wr_data_ok", data_data_ok, 1);
    @(negedge clk);
    chk("wr_ok_pulse", data_data_ok, 0);
    chk("wr_ok_count", data_ok_n - d0, 1);
  endtask
  task automatic wr_fields(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [2:0] sz);
    chk("awvalid", awvalid, 1);
    chk("wvalid", wvalid, 1);
    chk("awaddr", awaddr, a);
    chk("awid", awid, 1);
    chk("awsize", awsize, sz);
    chk("awlen", awlen, 0);
    chk("awburst", awburst, 1);
    chk("wdata", wdata, d);
    chk("wstrb", wstrb, s);
    chk("wlast", wlast, 1);
  endtask
  initial begin
    int i, d0, i0;
    @(negedge clk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_rdata", inst_rdata, 0);
    resetn = 1;
    @(negedge clk);
    // instruction read, slave answers on the 3rd RD_DATA cycle
    req(0, 0, 2, 32'hBFC00000, 0);
    chk("i_arsize", arsize, 2);
    chk("i_arlen", arlen, 0);
    chk("i_arburst", arburst, 1);
    rd_txn(0, 32'hBFC00000, 32'h3C1DA000, 2);
    chk("i_ok_count", inst_ok_n, 1);
    // simultaneous requests: data wins, inst waits for the next IDLE
    inst_req = 1; inst_addr = 32'hBFC00004; inst_size = 2;
    data_req = 1; data_wr = 0; data_addr = 32'h80001000; data_size = 2;
    #1 chk("cc_data_addr_ok", data_addr_ok, 1);
    chk("cc_inst_addr_ok", inst_addr_ok, 0);
    @(posedge clk); @(negedge clk);
    data_req = 0;
    chk("cc_no_addr_ok_busy", inst_addr_ok, 0);
    rd_txn(1, 32'h80001000, 32'h11223344, 0);
    chk("cc_inst_retry", inst_addr_ok, 1);
    @(posedge clk); @(negedge clk);
    inst_req = 0;
    rd_txn(0, 32'hBFC00004, 32'h27BDFFF0, 1);
    // byte store at lane 3, AW and W in the same cycle
    req(1, 1, 0, 32'h80000003, 32'h000000AB);
    wr_fields(32'h80000003, 32'h000000AB, 4'b1000, 3'd0);
    wr_txn(0, 0);
    // word store, AW late
    req(1, 1, 2, 32'h80000010, 32'hCAFEF00D);
    wr_fields(32'h80000010, 32'hCAFEF00D, 4'b1111, 3'd2);
    wr_txn(4, 0);
    // half store at upper half, W late
    req(1, 1, 1, 32'h80000006, 32'h12341234);
    wr_fields(32'h80000006, 32'h12341234, 4'b1100, 3'd1);
    wr_txn(0, 4);
    // reset while waiting for read data
    d0 = data_ok_n; i0 = inst_ok_n;
    req(1, 0, 2, 32'h80002000, 0);
    arready = 1;
    @(posedge clk); @(negedge clk);
    arready = 0;
    chk("mr_rready", rready, 1);
    resetn = 0;
    #1 chk("mr_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    repeat (2) @(negedge clk);
    resetn = 1;
    repeat (3) @(negedge clk);
    chk("mr_no_data_ok", data_ok_n - d0, 0);
    chk("mr_no_inst_ok", inst_ok_n - i0, 0);
    req(0, 0, 2, 32'hBFC00100, 0);
    rd_txn(0, 32'hBFC00100, 32'h0BADF00D, 0);
    // read that the slave never answers
    d0 = data_ok_n;
    req(1, 0, 2, 32'h80003000, 0);
    arready = 1;
    @(posedge clk); @(negedge clk);
    arready = 0;
`ifdef BRIDGE_TIMEOUT_EN
    i = 0;
    while (!data_data_ok && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk("to_latency", i, 255);
    chk("to_rdata", data_rdata, 32'hDEADBEEF);
    chk("to_bus_err", bus_err, 1);
    @(negedge clk);
    chk("to_err_pulse", bus_err, 0);
    chk("to_err_count", err_n, 1);
    chk("to_ok_count", data_ok_n - d0, 1);
`else
    repeat (300) @(negedge clk);
    chk("nt_waiting", rready, 1);
    chk("nt_no_ok", data_ok_n - d0, 0);
    chk("nt_no_err", err_n, 0);
    rvalid = 1; rdata = 32'h55AA55AA;
    @(posedge clk); @(negedge clk);
    rvalid = 0;
    chk("nt_late_ok", data_data_ok, 1);
    chk("nt_late_rdata", data_rdata, 32'h55AA55AA);
    @(negedge clk);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
